// File: rtl/prsnt_db_pkg.sv
// Shared types and constants for the presence-input debounce scheduler.
package prsnt_db_pkg;

    localparam int N_CH_DEF = 8;
    localparam int CW_DEF   = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // Index width; never below 1 so a single-channel build still has an index register.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/prsnt_db_cnt_upd.sv
// Shared per-channel debounce step, evaluated only on the channel visited this cycle.
module prsnt_db_cnt_upd
    import prsnt_db_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          in_i,
    input  logic          out_i,
    input  logic [CW-1:0] cnt_i,
    input  logic [CW-1:0] dly_i,
    input  logic          mask_i,
    output logic          out_o,
    output logic [CW-1:0] cnt_o,
    output logic          evt_set_o
);

    logic [CW:0] cnt_inc;

    assign cnt_inc = {1'b0, cnt_i} + {{CW{1'b0}}, 1'b1};

    always_comb begin
        out_o     = out_i;
        cnt_o     = cnt_i;
        evt_set_o = 1'b0;
        if (mask_i || (dly_i == '0) || (in_i == out_i)) begin
            cnt_o = '0;
        end else if (cnt_inc >= {1'b0, dly_i}) begin
            out_o     = in_i;
            cnt_o     = '0;
            evt_set_o = 1'b1;
        end else begin
            cnt_o = cnt_inc[CW] ? {CW{1'b1}} : cnt_inc[CW-1:0];
        end
    end

endmodule

// File: rtl/prsnt_db_scheduler.sv
// Round-robin debounce of N_CH presence inputs sharing one tick base and one compare path.
//   state   | meaning
//   ST_IDLE | waiting for iTick or a pending tick
//   ST_SCAN | visiting channel idx_q, one per cycle
module prsnt_db_scheduler
    import prsnt_db_pkg::*;
#(
    parameter int              N_CH    = N_CH_DEF,
    parameter int              CW      = CW_DEF,
    parameter logic [N_CH-1:0] RST_VAL = '0
) (
    input  logic            iCLK,
    input  logic            iRst_n,
    input  logic            iTick,
    input  logic [CW-1:0]   iDly_time,
    input  logic [N_CH-1:0] iPrsnt_in,
    input  logic [N_CH-1:0] iMask,
    input  logic [N_CH-1:0] iEvt_clr,
    output logic [N_CH-1:0] oPrsnt_out,
    output logic [N_CH-1:0] oChg_evt,
    output logic            oIrq,
    output logic            oOvr,
    output logic            oBusy
);

    localparam int            IW       = clog2(N_CH);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   dly_q, dly_d;
    logic            tick_pend_q, tick_pend_d;
    logic            ovr_q, ovr_d;
    logic [N_CH-1:0] out_q, out_d;
    logic [N_CH-1:0] evt_q, evt_d, evt_set;
    logic            irq_q;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];

    logic            bypass;
    logic            upd_out, upd_evt;
    logic [CW-1:0]   upd_cnt;

    assign bypass = (iDly_time == '0);

    always_comb begin : fsm_next
        state_d     = state_q;
        idx_d       = idx_q;
        dly_d       = dly_q;
        tick_pend_d = tick_pend_q;
        ovr_d       = ovr_q;
        case (state_q)
            ST_IDLE: begin
                if (iTick || tick_pend_q) begin
                    state_d     = ST_SCAN;
                    idx_d       = '0;
                    dly_d       = iDly_time;
                    tick_pend_d = 1'b0;
                end
            end
            ST_SCAN: begin
                if (iTick) begin
                    if (tick_pend_q) ovr_d = 1'b1;
                    else             tick_pend_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    // A tick absorbed during this scan starts the next one back-to-back.
                    if (tick_pend_q) begin
                        dly_d       = iDly_time;
                        tick_pend_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    prsnt_db_cnt_upd #(.CW(CW)) u_cnt_upd (
        .in_i      (iPrsnt_in[idx_q]),
        .out_i     (out_q[idx_q]),
        .cnt_i     (cnt_q[idx_q]),
        .dly_i     (dly_q),
        .mask_i    (iMask[idx_q]),
        .out_o     (upd_out),
        .cnt_o     (upd_cnt),
        .evt_set_o (upd_evt)
    );

    always_comb begin : datapath
        out_d   = out_q;
        evt_set = '0;
        for (int i = 0; i < N_CH; i++) cnt_d[i] = cnt_q[i];
        if (bypass) begin
            out_d   = (out_q & iMask) | (iPrsnt_in & ~iMask);
            evt_set = out_d ^ out_q;
            for (int i = 0; i < N_CH; i++) cnt_d[i] = '0;
        end else begin
            if (state_q == ST_SCAN) begin
                out_d[idx_q]   = upd_out;
                cnt_d[idx_q]   = upd_cnt;
                evt_set[idx_q] = upd_evt;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (iMask[i]) cnt_d[i] = '0;
            end
        end
        evt_d = (evt_q & ~iEvt_clr) | evt_set;
    end

    always_ff @(posedge iCLK or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            dly_q       <= '0;
            tick_pend_q <= 1'b0;
            ovr_q       <= 1'b0;
            out_q       <= RST_VAL;
            evt_q       <= '0;
            irq_q       <= 1'b0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dly_q       <= dly_d;
            tick_pend_q <= tick_pend_d;
            ovr_q       <= ovr_d;
            out_q       <= out_d;
            evt_q       <= evt_d;
            irq_q       <= |evt_d;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign oPrsnt_out = out_q;
    assign oChg_evt   = evt_q;
    assign oIrq       = irq_q;
    assign oOvr       = ovr_q;
    assign oBusy      = (state_q == ST_SCAN);

endmodule
